// File: rtl/mem_bus_arbiter.sv
// N-master arbiter for the PicoRV32 native memory interface: one slave shared by
// several masters, fixed or round-robin priority, per-transaction timeout.
module mem_bus_arbiter #(
    parameter int          NUM_MASTERS = 2,
    parameter int          RR_MODE     = 0,
    parameter int          TIMEOUT     = 255,
    parameter logic [31:0] ERR_RDATA   = 32'hDEAD_BEEF,
    parameter int          IDX_W       = $clog2(NUM_MASTERS)
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic [NUM_MASTERS-1:0]   m_valid,
    input  logic [NUM_MASTERS-1:0]   m_instr,
    input  logic [32*NUM_MASTERS-1:0] m_addr,
    input  logic [32*NUM_MASTERS-1:0] m_wdata,
    input  logic [4*NUM_MASTERS-1:0] m_wstrb,
    output logic [NUM_MASTERS-1:0]   m_ready,
    output logic [31:0]              m_rdata,
    output logic                     s_valid,
    output logic                     s_instr,
    output logic [31:0]              s_addr,
    output logic [31:0]              s_wdata,
    output logic [3:0]               s_wstrb,
    input  logic                     s_ready,
    input  logic [31:0]              s_rdata,
    output logic [IDX_W-1:0]         grant_idx,
    output logic                     busy,
    output logic                     timeout_err
);

    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    typedef struct packed {
        logic        instr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } req_t;

    state_t                 state;
    logic [CNT_W-1:0]       cnt;
    logic [IDX_W-1:0]       rr_ptr;
    logic [NUM_MASTERS-1:0] above, hi_req, pick_req, win_oh;
    logic [IDX_W-1:0]       win_idx;
    req_t                   win_req;

    // Round-robin: requesters above the pointer go first; if none, the lowest
    // requester overall wins, which is the wrap-around case.
    assign hi_req   = m_valid & above;
    assign pick_req = (|hi_req) ? hi_req : m_valid;
    assign win_oh   = pick_req & (~pick_req + NUM_MASTERS'(1));

    for (genvar g = 0; g < NUM_MASTERS; g++) begin : g_m
        req_t             req, acc_req;
        logic [IDX_W-1:0] acc_idx;
        assign above[g] = (RR_MODE != 0) && (IDX_W'(g) > rr_ptr);
        assign req = '{instr: m_instr[g], addr: m_addr[32*g +: 32],
                       wdata: m_wdata[32*g +: 32], wstrb: m_wstrb[4*g +: 4]};
        if (g == 0) begin : g_first
            assign acc_req = win_oh[g] ? req : '0;
            assign acc_idx = '0;
        end else begin : g_rest
            assign acc_req = g_m[g-1].acc_req | (win_oh[g] ? req : '0);
            assign acc_idx = g_m[g-1].acc_idx | (win_oh[g] ? IDX_W'(g) : '0);
        end
    end

    assign win_req = g_m[NUM_MASTERS-1].acc_req;
    assign win_idx = g_m[NUM_MASTERS-1].acc_idx;
    assign busy    = (state != IDLE);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state       <= IDLE;
            cnt         <= '0;
            rr_ptr      <= IDX_W'(NUM_MASTERS - 1);
            m_ready     <= '0;
            m_rdata     <= '0;
            s_valid     <= 1'b0;
            s_instr     <= 1'b0;
            s_addr      <= '0;
            s_wdata     <= '0;
            s_wstrb     <= '0;
            grant_idx   <= '0;
            timeout_err <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (|m_valid) begin
                        s_instr   <= win_req.instr;
                        s_addr    <= win_req.addr;
                        s_wdata   <= win_req.wdata;
                        s_wstrb   <= win_req.wstrb;
                        grant_idx <= win_idx;
                        rr_ptr    <= win_idx;
                        s_valid   <= 1'b1;
                        cnt       <= '0;
                        state     <= BUSY;
                    end
                end
                BUSY: begin
                    cnt <= cnt + CNT_W'(1);
                    // s_ready takes precedence over an expiring timeout
                    if (s_ready) begin
                        m_rdata <= s_rdata;
                        m_ready <= NUM_MASTERS'(1) << grant_idx;
                        s_valid <= 1'b0;
                        state   <= DONE;
                    end else if (TIMEOUT != 0 && cnt == CNT_W'(TIMEOUT - 1)) begin
                        m_rdata     <= ERR_RDATA;
                        m_ready     <= NUM_MASTERS'(1) << grant_idx;
                        s_valid     <= 1'b0;
                        timeout_err <= 1'b1;
                        state       <= DONE;
                    end
                end
                DONE: begin
                    // no arbitration here so a finished master's stale m_valid is not re-granted
                    m_ready <= '0;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Scoreboard bench: a fixed-priority and a round-robin arbiter share one stimulus
// stream; a transaction-level model predicts grants and completions for each.
module tb_mem_bus_arbiter;

    localparam int          N   = 3;
    localparam int          TO  = 4;
    localparam logic [31:0] ERR = 32'hDEAD_BEEF;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             reset_n;
    logic [N-1:0]     m_valid, m_instr;
    logic [32*N-1:0]  m_addr, m_wdata;
    logic [4*N-1:0]   m_wstrb;
    logic             s_ready;
    logic [31:0]      s_rdata;

    logic [N-1:0]     m_ready     [2];
    logic [31:0]      m_rdata     [2];
    logic             s_valid     [2];
    logic             s_instr     [2];
    logic [31:0]      s_addr      [2];
    logic [31:0]      s_wdata     [2];
    logic [3:0]       s_wstrb     [2];
    logic [1:0]       grant_idx   [2];
    logic             busy        [2];
    logic             timeout_err [2];

    mem_bus_arbiter #(.NUM_MASTERS(N), .RR_MODE(0), .TIMEOUT(TO)) u_fix (
        .clk(clk), .reset_n(reset_n), .m_valid(m_valid), .m_instr(m_instr),
        .m_addr(m_addr), .m_wdata(m_wdata), .m_wstrb(m_wstrb),
        .m_ready(m_ready[0]), .m_rdata(m_rdata[0]), .s_valid(s_valid[0]),
        .s_instr(s_instr[0]), .s_addr(s_addr[0]), .s_wdata(s_wdata[0]),
        .s_wstrb(s_wstrb[0]), .s_ready(s_ready), .s_rdata(s_rdata),
        .grant_idx(grant_idx[0]), .busy(busy[0]), .timeout_err(timeout_err[0]));

    mem_bus_arbiter #(.NUM_MASTERS(N), .RR_MODE(1), .TIMEOUT(TO)) u_rr (
        .clk(clk), .reset_n(reset_n), .m_valid(m_valid), .m_instr(m_instr),
        .m_addr(m_addr), .m_wdata(m_wdata), .m_wstrb(m_wstrb),
        .m_ready(m_ready[1]), .m_rdata(m_rdata[1]), .s_valid(s_valid[1]),
        .s_instr(s_instr[1]), .s_addr(s_addr[1]), .s_wdata(s_wdata[1]),
        .s_wstrb(s_wstrb[1]), .s_ready(s_ready), .s_rdata(s_rdata),
        .grant_idx(grant_idx[1]), .busy(busy[1]), .timeout_err(timeout_err[1]));

    typedef struct packed {
        logic [1:0]  idx;
        logic        instr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } sreq_t;

    typedef struct packed {
        logic [N-1:0] rdy;
        logic [31:0]  rdata;
        logic         err;
    } cmp_t;

    sreq_t sq [2][$];
    cmp_t  cq [2][$];
    int    vec  = 0;
    int    miss = 0;
    bit    done = 1'b0;

    // ---------------- reference model (stimulus side) ----------------
    int last  [2];
    bit err_m [2];

    // Grant order: fixed = 0..N-1; round-robin = the N masters after the last winner.
    function automatic int pick(input logic [N-1:0] v, input bit rr, input int lst);
        for (int k = 1; k <= N; k++) begin
            int           c;
            logic [N-1:0] t;
            c = rr ? (lst + k) % N : k - 1;
            t = v >> c;
            if (t[0]) return c;
        end
        return 0;
    endfunction

    task automatic rand_payload();
        m_instr = N'($urandom);
        m_addr  = {$urandom, $urandom, $urandom};
        m_wdata = {$urandom, $urandom, $urandom};
        m_wstrb = (4*N)'($urandom);
    endtask

    task automatic push(input bit k, input logic [N-1:0] v, input int dly,
                        input bit rst, input logic [31:0] val);
        int    w;
        sreq_t s;
        cmp_t  c;
        bit    to;
        w       = pick(v, k, last[k]);
        last[k] = w;
        s.idx   = 2'(w);
        s.instr = 1'(m_instr >> w);
        s.addr  = 32'(m_addr >> (32*w));
        s.wdata = 32'(m_wdata >> (32*w));
        s.wstrb = 4'(m_wstrb >> (4*w));
        sq[k].push_back(s);
        if (!rst) begin
            to       = (dly >= TO);
            err_m[k] = err_m[k] | to;
            c.rdy    = N'(1 << w);
            c.rdata  = to ? ERR : val;
            c.err    = err_m[k];
            cq[k].push_back(c);
        end
    endtask

    // One arbitration slot. Slave answers dly cycles after s_valid rises
    // (dly >= TO means it never answers in time). rst aborts the access mid-flight.
    task automatic txn(input logic [N-1:0] v, input int dly, input bit rst,
                       input logic [31:0] val);
        m_valid = v;
        s_ready = 1'b0;
        if (v == '0) begin
            @(negedge clk);
            return;
        end
        for (int k = 0; k < 2; k++) push(k[0], v, dly, rst, val);
        @(negedge clk);
        m_valid = N'($urandom);
        rand_payload();
        for (int j = 0; j < 64; j++) begin
            s_ready = (j == dly);
            s_rdata = (j == dly) ? val : $urandom;
            if (rst && j == 1) begin
                reset_n = 1'b0;
                for (int k = 0; k < 2; k++) begin
                    last[k]  = N - 1;
                    err_m[k] = 1'b0;
                end
                @(negedge clk);
                reset_n = 1'b1;
                s_ready = 1'b0;
                m_valid = '0;
                return;
            end
            @(negedge clk);
            if (j == dly || j == TO - 1) break;
        end
        s_ready = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        int v, d;
        bit r;
        reset_n = 1'b0;
        m_valid = '0; m_instr = '0; m_addr = '0; m_wdata = '0; m_wstrb = '0;
        s_ready = 1'b0; s_rdata = '0;
        for (int k = 0; k < 2; k++) begin
            last[k]  = N - 1;
            err_m[k] = 1'b0;
        end
        repeat (2) @(negedge clk);
        reset_n = 1'b1;

        rand_payload();
        m_addr[31:0] = 32'h0000_0010;
        txn(3'b001, 2, 1'b0, 32'h1234_5678);
        rand_payload();
        m_addr[63:32]  = 32'h0000_0020;
        m_wdata[63:32] = 32'hA5A5_A5A5;
        m_wstrb[7:4]   = 4'b0011;
        txn(3'b010, 1, 1'b0, $urandom);
        repeat (4) begin
            rand_payload();
            txn(3'b111, $urandom_range(0, 3), 1'b0, $urandom);
        end
        rand_payload(); txn(3'b011, TO - 1, 1'b0, $urandom);
        rand_payload(); txn(3'b110, TO,     1'b0, $urandom);
        rand_payload(); txn(3'b101, 0,      1'b0, $urandom);
        rand_payload(); txn(3'b110, 5,      1'b1, $urandom);
        rand_payload(); txn(3'b100, 1,      1'b0, $urandom);

        repeat (150) begin
            v = $urandom_range(0, 7);
            r = ($urandom_range(0, 39) == 0);
            d = r ? 5 : $urandom_range(0, 6);
            rand_payload();
            txn(N'(v), d, r, $urandom);
        end
        m_valid = '0;
        done = 1'b1;
        repeat (4) @(negedge clk);
    end

    // ---------------- monitor / scoreboard ----------------
    logic  sv_prev [2];
    sreq_t cur     [2];
    logic [31:0] last_rd [2];
    bit    rst_s;

    task automatic chk(input string nm, input bit d, input logic [31:0] act,
                       input logic [31:0] exp);
        vec++;
        if (act !== exp) begin
            miss++;
            $display("FAIL %s dut%0d @%0t: got %h expected %h", nm, d, $time, act, exp);
        end
    endtask

    task automatic mon(input bit d);
        cmp_t c;
        if (rst_s) begin
            chk("rst_s_valid",     d, 32'(s_valid[d]),     0);
            chk("rst_m_ready",     d, 32'(m_ready[d]),     0);
            chk("rst_busy",        d, 32'(busy[d]),        0);
            chk("rst_timeout_err", d, 32'(timeout_err[d]), 0);
            chk("rst_grant_idx",   d, 32'(grant_idx[d]),   0);
            chk("rst_m_rdata",     d, m_rdata[d],          0);
            chk("rst_s_addr",      d, s_addr[d],           0);
            sv_prev[d] = 1'b0;
            last_rd[d] = '0;
            return;
        end
        if (s_valid[d] && !sv_prev[d]) begin
            if (sq[d].size() == 0) chk("unexp_s_valid", d, 32'(s_valid[d]), 0);
            else begin
                cur[d] = sq[d].pop_front();
                chk("grant_idx", d, 32'(grant_idx[d]), 32'(cur[d].idx));
            end
        end
        if (s_valid[d]) begin
            chk("s_addr",  d, s_addr[d],           cur[d].addr);
            chk("s_wdata", d, s_wdata[d],          cur[d].wdata);
            chk("s_wstrb", d, 32'(s_wstrb[d]),     32'(cur[d].wstrb));
            chk("s_instr", d, 32'(s_instr[d]),     32'(cur[d].instr));
            chk("busy",    d, 32'(busy[d]),        1);
        end
        if (m_ready[d] != '0) begin
            if (cq[d].size() == 0) chk("unexp_m_ready", d, 32'(m_ready[d]), 0);
            else begin
                c = cq[d].pop_front();
                chk("m_ready",     d, 32'(m_ready[d]),     32'(c.rdy));
                chk("m_rdata",     d, m_rdata[d],          c.rdata);
                chk("timeout_err", d, 32'(timeout_err[d]), 32'(c.err));
                chk("busy_done",   d, 32'(busy[d]),        1);
                last_rd[d] = c.rdata;
            end
        end else begin
            chk("m_rdata_hold", d, m_rdata[d], last_rd[d]);
        end
        sv_prev[d] = s_valid[d];
    endtask

    always @(posedge clk) begin
        rst_s = !reset_n;
        #1;
        for (int k = 0; k < 2; k++) mon(k[0]);
        if (done) begin
            for (int k = 0; k < 2; k++) begin
                chk("grants_left",      k[0], 32'(sq[k].size()), 0);
                chk("completions_left", k[0], 32'(cq[k].size()), 0);
            end
            $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
            $finish;
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: run did not end, got timeout expected finish");
        $fatal(1);
    end

endmodule
